// File: rtl/moving_obstacle.sv
// Rectangular stage obstacle: static, or ping-pong along X or Y once per frame with an
// optional dwell at each end. Provides the pixel hit flag, position/displacement and fighter overlap.
module moving_obstacle #(
    parameter int unsigned HALF_W       = 23,
    parameter int unsigned HALF_H       = 47,
    parameter int unsigned X_START      = 320,
    parameter int unsigned Y_START      = 432,
    parameter int unsigned MODE         = 1,
    parameter int unsigned POS_MIN      = 200,
    parameter int unsigned POS_MAX      = 440,
    parameter int unsigned STEP         = 2,
    parameter int unsigned PAUSE_FRAMES = 30
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              enable,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        pl_x,
    input  logic [9:0]        pl_y,
    input  logic [7:0]        pl_hw,
    input  logic [7:0]        pl_hh,
    output logic              is_obj,
    output logic [9:0]        obj_x,
    output logic [9:0]        obj_y,
    output logic signed [9:0] obj_dx,
    output logic              obj_dir,
    output logic              hit
);

    typedef enum logic [1:0] {
        MOVE_POS  = 2'd0,
        PAUSE_POS = 2'd1,
        MOVE_NEG  = 2'd2,
        PAUSE_NEG = 2'd3
    } state_t;

    localparam logic [10:0] HW_W   = 11'(HALF_W);
    localparam logic [10:0] HH_W   = 11'(HALF_H);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] MIN_W  = 11'(POS_MIN);
    localparam logic [10:0] MAX_W  = 11'(POS_MAX);
    localparam logic [15:0] CNT_W  = 16'(PAUSE_FRAMES);
    localparam bit          IS_VERT = (MODE == 32'd2);
    localparam bit          IS_STATIC = (MODE == 32'd0);
    localparam bit          NO_PAUSE = (PAUSE_FRAMES == 32'd0);

    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    state_t      state_r;
    state_t      st_nxt_s;
    logic [15:0] pause_cnt_r;
    logic [15:0] cnt_nxt_s;
    logic        frame_d_r;
    logic        tick_s;
    logic [10:0] p_s;
    logic [10:0] up_s;
    logic [10:0] p_nxt_s;
    logic [10:0] dx_nxt_s;
    logic        dir_nxt_s;
    logic        hit_s;

    assign tick_s = frame_clk & ~frame_d_r & ~Reset;
    assign p_s    = IS_VERT ? {1'b0, obj_y} : {1'b0, obj_x};
    assign up_s   = p_s + STEP_W;

    assign is_obj = ({1'b0, DrawX} + HW_W >= {1'b0, obj_x}) &&
                    ({1'b0, DrawX} <= {1'b0, obj_x} + HW_W) &&
                    ({1'b0, DrawY} + HH_W >= {1'b0, obj_y}) &&
                    ({1'b0, DrawY} <= {1'b0, obj_y} + HH_W);

    assign hit_s = (abs_diff(pl_x, obj_x) <= {3'b000, pl_hw} + HW_W) &&
                   (abs_diff(pl_y, obj_y) <= {3'b000, pl_hh} + HH_W);

    // Next motion state for one enabled tick; the lower clamp avoids p-STEP underflow.
    always_comb begin
        st_nxt_s  = state_r;
        cnt_nxt_s = pause_cnt_r;
        p_nxt_s   = p_s;
        dx_nxt_s  = 11'd0;
        dir_nxt_s = obj_dir;
        case (state_r)
            MOVE_POS: begin
                if (up_s >= MAX_W) begin
                    p_nxt_s  = MAX_W;
                    dx_nxt_s = MAX_W - p_s;
                    if (NO_PAUSE) begin
                        st_nxt_s  = MOVE_NEG;
                        dir_nxt_s = 1'b1;
                    end else begin
                        st_nxt_s  = PAUSE_POS;
                        cnt_nxt_s = CNT_W;
                    end
                end else begin
                    p_nxt_s  = up_s;
                    dx_nxt_s = STEP_W;
                end
            end
            PAUSE_POS: begin
                if (pause_cnt_r == 16'd1) begin
                    st_nxt_s  = MOVE_NEG;
                    dir_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = pause_cnt_r - 16'd1;
                end
            end
            MOVE_NEG: begin
                if (p_s <= MIN_W + STEP_W) begin
                    p_nxt_s  = MIN_W;
                    dx_nxt_s = MIN_W - p_s;
                    if (NO_PAUSE) begin
                        st_nxt_s  = MOVE_POS;
                        dir_nxt_s = 1'b0;
                    end else begin
                        st_nxt_s  = PAUSE_NEG;
                        cnt_nxt_s = CNT_W;
                    end
                end else begin
                    p_nxt_s  = p_s - STEP_W;
                    dx_nxt_s = 11'd0 - STEP_W;
                end
            end
            PAUSE_NEG: begin
                if (pause_cnt_r == 16'd1) begin
                    st_nxt_s  = MOVE_POS;
                    dir_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = pause_cnt_r - 16'd1;
                end
            end
            default: begin
                st_nxt_s = MOVE_POS;
            end
        endcase
    end

    // Edge detect, motion FSM and overlap register.
    always_ff @(posedge Clk) begin
        frame_d_r <= frame_clk;
        if (Reset) begin
            obj_x       <= 10'(X_START);
            obj_y       <= 10'(Y_START);
            state_r     <= MOVE_POS;
            pause_cnt_r <= 16'd0;
            obj_dx      <= 10'sd0;
            obj_dir     <= 1'b0;
            hit         <= 1'b0;
        end else begin
            hit <= hit_s;
            if (tick_s) begin
                if (enable && !IS_STATIC) begin
                    state_r     <= st_nxt_s;
                    pause_cnt_r <= cnt_nxt_s;
                    obj_dir     <= dir_nxt_s;
                    obj_dx      <= dx_nxt_s[9:0];
                    if (IS_VERT) begin
                        obj_y <= p_nxt_s[9:0];
                    end else begin
                        obj_x <= p_nxt_s[9:0];
                    end
                end else begin
                    obj_dx <= 10'sd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_moving_obstacle.sv
// Directed bench for moving_obstacle: default, STEP=7, vertical and static instances share stimulus.
module tb_moving_obstacle;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic       enable = 1'b1;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic [9:0] pl_x = 10'd0;
    logic [9:0] pl_y = 10'd0;
    logic [7:0] pl_hw = 8'd0;
    logic [7:0] pl_hh = 8'd0;

    logic              is_obj, obj_dir, hit;
    logic [9:0]        obj_x, obj_y;
    logic signed [9:0] obj_dx;
    logic              s7_is_obj, s7_dir, s7_hit;
    logic [9:0]        s7_x, s7_y;
    logic signed [9:0] s7_dx;
    logic              v_is_obj, v_dir, v_hit;
    logic [9:0]        v_x, v_y;
    logic signed [9:0] v_dx;
    logic              st_is_obj, st_dir, st_hit;
    logic [9:0]        st_x, st_y;
    logic signed [9:0] st_dx;

    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    moving_obstacle u_dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
        .DrawX(DrawX), .DrawY(DrawY), .pl_x(pl_x), .pl_y(pl_y), .pl_hw(pl_hw), .pl_hh(pl_hh),
        .is_obj(is_obj), .obj_x(obj_x), .obj_y(obj_y), .obj_dx(obj_dx), .obj_dir(obj_dir), .hit(hit)
    );

    moving_obstacle #(.STEP(7)) u_s7 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
        .DrawX(DrawX), .DrawY(DrawY), .pl_x(pl_x), .pl_y(pl_y), .pl_hw(pl_hw), .pl_hh(pl_hh),
        .is_obj(s7_is_obj), .obj_x(s7_x), .obj_y(s7_y), .obj_dx(s7_dx), .obj_dir(s7_dir), .hit(s7_hit)
    );

    moving_obstacle #(.MODE(2), .POS_MIN(300), .POS_MAX(432), .Y_START(432)) u_v (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
        .DrawX(DrawX), .DrawY(DrawY), .pl_x(pl_x), .pl_y(pl_y), .pl_hw(pl_hw), .pl_hh(pl_hh),
        .is_obj(v_is_obj), .obj_x(v_x), .obj_y(v_y), .obj_dx(v_dx), .obj_dir(v_dir), .hit(v_hit)
    );

    moving_obstacle #(.MODE(0)) u_st (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
        .DrawX(DrawX), .DrawY(DrawY), .pl_x(pl_x), .pl_y(pl_y), .pl_hw(pl_hw), .pl_hh(pl_hh),
        .is_obj(st_is_obj), .obj_x(st_x), .obj_y(st_y), .obj_dx(st_dx), .obj_dir(st_dir), .hit(st_hit)
    );

    typedef struct {
        logic [9:0] dx;
        logic [9:0] dy;
        logic       exp;
    } pix_vec_t;

    typedef struct {
        logic [9:0] px;
        logic       exp;
    } hit_vec_t;

    pix_vec_t pix_tab [5];
    hit_vec_t hit_tab [4];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // n rising edges of frame_clk, each held high for 'hold' clocks.
    task automatic ticks(input int n, input int hold);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            frame_clk = 1'b1;
            repeat (hold) @(negedge Clk);
            frame_clk = 1'b0;
            @(negedge Clk);
        end
    endtask

    initial begin
        pix_tab[0] = '{10'd297, 10'd385, 1'b1};
        pix_tab[1] = '{10'd296, 10'd385, 1'b0};
        pix_tab[2] = '{10'd343, 10'd385, 1'b1};
        pix_tab[3] = '{10'd344, 10'd385, 1'b0};
        pix_tab[4] = '{10'd320, 10'd480, 1'b0};
        hit_tab[0] = '{10'd370, 1'b0};
        hit_tab[1] = '{10'd347, 1'b1};
        hit_tab[2] = '{10'd293, 1'b1};
        hit_tab[3] = '{10'd292, 1'b0};

        // Reset state and pixel window.
        do_reset();
        @(negedge Clk);
        check("rst_x", int'(obj_x), 320);
        check("rst_y", int'(obj_y), 432);
        check("rst_dx", int'(obj_dx), 0);
        check("rst_dir", int'(obj_dir), 0);
        check("rst_hit", int'(hit), 0);
        for (int i = 0; i < 5; i++) begin
            DrawX = pix_tab[i].dx;
            DrawY = pix_tab[i].dy;
            #1;
            check($sformatf("is_obj[%0d]", i), int'(is_obj), int'(pix_tab[i].exp));
        end

        // Overlap: one-cycle latency, then table of edge cases.
        pl_y = 10'd432; pl_hh = 8'd10; pl_hw = 8'd4;
        pl_x = 10'd370;
        @(negedge Clk);
        pl_x = 10'd347;
        #1;
        check("hit_latency_old", int'(hit), 0);
        @(negedge Clk);
        check("hit_latency_new", int'(hit), 1);
        for (int i = 0; i < 4; i++) begin
            pl_x = hit_tab[i].px;
            @(negedge Clk);
            check($sformatf("hit[%0d]", i), int'(hit), int'(hit_tab[i].exp));
        end
        pl_x = 10'd0;

        // Long-held pulses give one tick each; enable=0 freezes.
        ticks(10, 100);
        check("run10_x", int'(obj_x), 340);
        check("run10_dx", int'(obj_dx), 2);
        check("run10_dir", int'(obj_dir), 0);
        check("run10_y", int'(obj_y), 432);
        check("static_x", int'(st_x), 320);
        check("static_dx", int'(st_dx), 0);
        enable = 1'b0;
        ticks(20, 3);
        check("frozen_x", int'(obj_x), 340);
        check("frozen_dx", int'(obj_dx), 0);
        enable = 1'b1;

        // Arrival, dwell and reversal.
        do_reset();
        ticks(60, 1);
        check("arrive_x", int'(obj_x), 440);
        check("arrive_dx", int'(obj_dx), 2);
        ticks(29, 1);
        check("dwell_x", int'(obj_x), 440);
        check("dwell_dx", int'(obj_dx), 0);
        check("dwell_dir", int'(obj_dir), 0);
        ticks(1, 1);
        check("dwell_end_x", int'(obj_x), 440);
        check("dwell_end_dir", int'(obj_dir), 1);
        ticks(1, 1);
        check("reverse_x", int'(obj_x), 438);
        check("reverse_dx", int'(obj_dx), -2);

        // Clamped arrivals for STEP=7 and vertical mode.
        do_reset();
        ticks(1, 1);
        check("v_first_y", int'(v_y), 432);
        check("v_first_dx", int'(v_dx), 0);
        ticks(16, 1);
        check("s7_17_x", int'(s7_x), 439);
        check("v_pause_y", int'(v_y), 432);
        check("v_pause_dx", int'(v_dx), 0);
        check("v_x_const", int'(v_x), 320);
        check("v_dir", int'(v_dir), 0);
        ticks(1, 1);
        check("s7_clamp_x", int'(s7_x), 440);
        check("s7_clamp_dx", int'(s7_dx), 1);

        // Reset mid-pause with frame_clk held high across release.
        do_reset();
        ticks(78, 1);
        check("midpause_x", int'(obj_x), 440);
        @(negedge Clk);
        Reset = 1'b1;
        frame_clk = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("mid_rst_x", int'(obj_x), 320);
        check("mid_rst_dx", int'(obj_dx), 0);
        check("mid_rst_dir", int'(obj_dir), 0);
        repeat (5) @(negedge Clk);
        check("no_tick_on_release", int'(obj_x), 320);
        frame_clk = 1'b0;
        ticks(1, 1);
        check("post_rst_x", int'(obj_x), 322);
        check("post_rst_dx", int'(obj_dx), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
